// File: rtl/ext_unit_pipe_pkg.sv
// Shared definitions for the pipelined immediate/operand extender:
// the extension mode codes and the occupancy state encoding.
package ext_pkg;

   // Extension modes carried on in_mode
   localparam logic [1:0] EXT_SIGN  = 2'd0;
   localparam logic [1:0] EXT_ZERO  = 2'd1;
   localparam logic [1:0] EXT_UPPER = 2'd2;
   localparam logic [1:0] EXT_BYTE  = 2'd3;

   // Occupancy of the output register / skid register pair
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_state_t;

endpackage

// File: rtl/ext_unit_pipe_if.sv
// Valid/ready bundle for the extender: the input side and the
// output side travel together. The unit takes the slave view.
interface ext_unit_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic [1:0]       in_mode;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_mode, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_mode, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag
   );
endinterface

// File: rtl/ext_unit_pipe_core.sv
// Combinational extension of an IN_W-bit field to OUT_W bits.
// When IN_W == OUT_W the pad width is zero, so sign/zero/upper collapse
// to a plain pass-through while the byte mode still sign-extends bit 7.
module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  data,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] result
);
   localparam int PAD_W = OUT_W - IN_W;

   logic [OUT_W-1:0] sign_ext;
   logic [OUT_W-1:0] zero_ext;
   logic [OUT_W-1:0] upper_ext;
   logic [OUT_W-1:0] byte_ext;

   // Width casts handle the zero-pad case without special generate branches
   assign sign_ext  = OUT_W'($signed(data));
   assign zero_ext  = OUT_W'(data);
   assign upper_ext = OUT_W'(data) << PAD_W;
   assign byte_ext  = OUT_W'($signed(data[7:0]));

   // Mode select
   always_comb begin
      result = sign_ext;
      case (mode)
         EXT_SIGN:  result = sign_ext;
         EXT_ZERO:  result = zero_ext;
         EXT_UPPER: result = upper_ext;
         EXT_BYTE:  result = byte_ext;
         default:   result = sign_ext;
      endcase
   end
endmodule

// File: rtl/ext_unit_pipe.sv
// Pipelined extender: the result is computed on the input side and held
// in an output register backed by a one-entry skid register, so in_ready
// comes straight from a flop and throughput stays at one per cycle.
module ext_unit_pipe
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   ext_unit_pipe_if.slave bus
);
   // Reject illegal width combinations while elaborating
   generate
      if (IN_W < 8 || IN_W > OUT_W) begin : g_bad_width
         $error("ext_unit_pipe: IN_W must satisfy 8 <= IN_W <= OUT_W");
      end
   endgenerate

   occ_state_t       state_reg;
   logic             out_valid_reg;
   logic             in_ready_reg;
   logic [OUT_W-1:0] out_data_reg;
   logic [TAG_W-1:0] out_tag_reg;
   logic [OUT_W-1:0] skid_data_reg;
   logic [TAG_W-1:0] skid_tag_reg;

   logic [OUT_W-1:0] ext_result;
   logic             accept;
   logic             consume;

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .data   (bus.in_data),
      .mode   (bus.in_mode),
      .result (ext_result)
   );

   assign accept  = bus.in_valid && in_ready_reg;
   assign consume = out_valid_reg && bus.out_ready;

   // Occupancy FSM with registered handshake outputs and data stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_EMPTY;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_data_reg  <= '0;
         out_tag_reg   <= '0;
         skid_data_reg <= '0;
         skid_tag_reg  <= '0;
      end else if (flush) begin
         // Clearing the valid flags is enough to discard both stages
         state_reg     <= ST_EMPTY;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               if (accept) begin
                  out_data_reg  <= ext_result;
                  out_tag_reg   <= bus.in_tag;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  out_data_reg <= ext_result;
                  out_tag_reg  <= bus.in_tag;
               end else if (accept) begin
                  skid_data_reg <= ext_result;
                  skid_tag_reg  <= bus.in_tag;
                  in_ready_reg  <= 1'b0;
                  state_reg     <= ST_TWO;
               end else if (consume) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (consume) begin
                  out_data_reg <= skid_data_reg;
                  out_tag_reg  <= skid_tag_reg;
                  in_ready_reg <= 1'b1;
                  state_reg    <= ST_ONE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= ST_EMPTY;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_tag   = out_tag_reg;
endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed and randomised checks of the pipelined extender, with two
// extra instances covering the narrow (8->16) and equal-width (32->32) cases.
module tb_ext_unit_pipe;
   logic clk_tb = 1'b0;
   logic rst;
   logic flush;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk_tb = ~clk_tb;

   ext_unit_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus   ();
   ext_unit_pipe_if #(.IN_W(8),  .OUT_W(16), .TAG_W(5)) bus8  ();
   ext_unit_pipe_if #(.IN_W(32), .OUT_W(32), .TAG_W(5)) bus32 ();

   ext_unit_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
      .clk(clk_tb), .rst(rst), .flush(flush), .bus(bus));
   ext_unit_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut8 (
      .clk(clk_tb), .rst(rst), .flush(flush), .bus(bus8));
   ext_unit_pipe #(.IN_W(32), .OUT_W(32), .TAG_W(5)) dut32 (
      .clk(clk_tb), .rst(rst), .flush(flush), .bus(bus32));

   // Reference extension for the 16->32 instance
   function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
      case (m)
         2'd0:    model = d[15] ? {16'hFFFF, d} : {16'h0000, d};
         2'd1:    model = {16'h0000, d};
         2'd2:    model = {d, 16'h0000};
         default: model = d[7] ? {24'hFFFFFF, d[7:0]} : {24'h000000, d[7:0]};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk_tb);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
      checks++; if (bus.out_tag !== 5'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", bus.out_tag); end
      rst = 1'b0;
      tick();
      $display("reset: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
   endtask

   task automatic test_modes();
      logic [15:0] d [4] = '{16'h8001, 16'h8001, 16'h1234, 16'h1280};
      logic [31:0] e [4] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFF80};
      for (int i = 0; i < 4; i++) begin
         bus.out_ready = 1'b1;
         bus.in_valid  = 1'b1;
         bus.in_data   = d[i];
         bus.in_mode   = 2'(i);
         bus.in_tag    = 5'(10 + i);
         checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mode%0d_pre_valid got=%b exp=0", i, bus.out_valid); end
         tick();
         bus.in_valid = 1'b0;
         checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mode%0d_valid got=%b exp=1", i, bus.out_valid); end
         checks++; if (bus.out_data !== e[i]) begin failures++; $display("FAIL mode%0d_data got=%h exp=%h", i, bus.out_data, e[i]); end
         checks++; if (bus.out_tag !== 5'(10 + i)) begin failures++; $display("FAIL mode%0d_tag got=%0d exp=%0d", i, bus.out_tag, 10 + i); end
         $display("mode %0d: in=%h out=%h tag=%0d", i, d[i], bus.out_data, bus.out_tag);
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] seen_tag [$];
      logic [31:0] seen_data [$];
      int seen_cyc [$];
      bus.out_ready = 1'b0;
      bus.in_mode   = 2'd1;
      bus.in_valid  = 1'b1;
      bus.in_data = 16'd1; bus.in_tag = 5'd1;
      tick();
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after1 got=%b exp=1", bus.in_ready); end
      bus.in_data = 16'd2; bus.in_tag = 5'd2;
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after2 got=%b exp=0", bus.in_ready); end
      bus.in_data = 16'd3; bus.in_tag = 5'd3;
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_held got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_tag !== 5'd1) begin failures++; $display("FAIL bp_out_held got=%0d exp=1", bus.out_tag); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         logic drop;
         drop = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            seen_tag.push_back(bus.out_tag);
            seen_data.push_back(bus.out_data);
            seen_cyc.push_back(c);
            $display("bp drain: cycle=%0d tag=%0d data=%h", c, bus.out_tag, bus.out_data);
         end
         tick();
         if (drop) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0;
      checks++; if (seen_tag.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", seen_tag.size()); end
      for (int k = 0; k < 3; k++) begin
         if (k < seen_tag.size()) begin
            checks++; if (seen_tag[k] !== 5'(k + 1)) begin failures++; $display("FAIL bp_order%0d got=%0d exp=%0d", k, seen_tag[k], k + 1); end
            checks++; if (seen_data[k] !== 32'(k + 1)) begin failures++; $display("FAIL bp_data%0d got=%h exp=%h", k, seen_data[k], k + 1); end
            checks++; if (seen_cyc[k] != k) begin failures++; $display("FAIL bp_gap%0d got=%0d exp=%0d", k, seen_cyc[k], k); end
         end
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp_q [$];
      logic [4:0]  tag_q [$];
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      logic rdy_a;
      while ((sent < 1000 || got < sent) && cyc < 20000) begin
         bus.in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 8);
         bus.in_data   = 16'($urandom);
         bus.in_mode   = 2'($urandom_range(0, 3));
         bus.in_tag    = 5'($urandom);
         bus.out_ready = (sent >= 1000) || ($urandom_range(0, 9) < 7);
         rdy_a = bus.in_ready;
         bus.out_ready = !bus.out_ready;
         #1;
         checks++; if (bus.in_ready !== rdy_a) begin failures++; $display("FAIL stream_ready_indep cyc=%0d got=%b exp=%b", cyc, bus.in_ready, rdy_a); end
         bus.out_ready = !bus.out_ready;
         #1;
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL stream_extra cyc=%0d got=%h exp=none", cyc, bus.out_data);
            end else begin
               if (bus.out_data !== exp_q[0] || bus.out_tag !== tag_q[0]) begin
                  failures++;
                  $display("FAIL stream_out cyc=%0d got=%h/%0d exp=%h/%0d", cyc, bus.out_data, bus.out_tag, exp_q[0], tag_q[0]);
               end
               void'(exp_q.pop_front());
               void'(tag_q.pop_front());
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.in_data, bus.in_mode));
            tag_q.push_back(bus.in_tag);
            sent++;
         end
         @(posedge clk_tb);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      checks++; if (got != 1000) begin failures++; $display("FAIL stream_count got=%0d exp=1000", got); end
      $display("stream: sent=%0d received=%0d cycles=%0d", sent, got, cyc);
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      bus.in_mode   = 2'd0;
      bus.in_valid  = 1'b1;
      bus.in_data = 16'h0101; bus.in_tag = 5'd7;
      tick();
      bus.in_data = 16'h0202; bus.in_tag = 5'd8;
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_two got=%b exp=0", bus.in_ready); end
      bus.in_data = 16'h0909; bus.in_tag = 5'd9;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_output c=%0d got=%b tag=%0d exp=0", c, bus.out_valid, bus.out_tag); end
      end
      $display("flush: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data = 16'h00AB; bus.in_mode = 2'd1; bus.in_tag = 5'd7;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b exp=1", bus.out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL arst_out_data got=%h exp=0", bus.out_data); end
      checks++; if (bus.out_tag !== 5'h0) begin failures++; $display("FAIL arst_out_tag got=%0d exp=0", bus.out_tag); end
      #1 rst = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data = 16'hFFFE; bus.in_mode = 2'd0; bus.in_tag = 5'd3;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_post_valid got=%b exp=1", bus.out_valid); end
      checks++; if (bus.out_data !== 32'hFFFFFFFE) begin failures++; $display("FAIL arst_post_data got=%h exp=fffffffe", bus.out_data); end
      checks++; if (bus.out_tag !== 5'd3) begin failures++; $display("FAIL arst_post_tag got=%0d exp=3", bus.out_tag); end
      $display("async reset: post-release out=%h tag=%0d", bus.out_data, bus.out_tag);
      tick();
   endtask

   task automatic test_param_sweep();
      logic [1:0]  m   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      logic [7:0]  d8  [5] = '{8'h85, 8'h85, 8'h85, 8'h85, 8'h7F};
      logic [15:0] e16 [5] = '{16'hFF85, 16'h0085, 16'h8500, 16'hFF85, 16'h007F};
      logic [31:0] d32 [5] = '{32'h80001234, 32'h80001234, 32'h80001234, 32'h12345680, 32'hFFFFFF7F};
      logic [31:0] e32 [5] = '{32'h80001234, 32'h80001234, 32'h80001234, 32'hFFFFFF80, 32'h0000007F};
      for (int i = 0; i < 5; i++) begin
         bus8.out_ready = 1'b1;  bus32.out_ready = 1'b1;
         bus8.in_valid  = 1'b1;  bus32.in_valid  = 1'b1;
         bus8.in_mode   = m[i];  bus32.in_mode   = m[i];
         bus8.in_data   = d8[i]; bus32.in_data   = d32[i];
         bus8.in_tag    = 5'(i); bus32.in_tag    = 5'(20 + i);
         tick();
         bus8.in_valid = 1'b0; bus32.in_valid = 1'b0;
         checks++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== e16[i] || bus8.out_tag !== 5'(i)) begin
            failures++; $display("FAIL sweep8_%0d got=%b/%h/%0d exp=1/%h/%0d", i, bus8.out_valid, bus8.out_data, bus8.out_tag, e16[i], i);
         end
         checks++; if (bus32.out_valid !== 1'b1 || bus32.out_data !== e32[i] || bus32.out_tag !== 5'(20 + i)) begin
            failures++; $display("FAIL sweep32_%0d got=%b/%h/%0d exp=1/%h/%0d", i, bus32.out_valid, bus32.out_data, bus32.out_tag, e32[i], 20 + i);
         end
         $display("sweep mode %0d: 8->16 %h->%h  32->32 %h->%h", m[i], d8[i], bus8.out_data, d32[i], bus32.out_data);
         tick();
      end
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
      bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_mode = '0; bus8.in_tag = '0; bus8.out_ready = 1'b1;
      bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.in_mode = '0; bus32.in_tag = '0; bus32.out_ready = 1'b1;
      test_reset();
      test_modes();
      test_backpressure();
      test_stream();
      test_flush();
      test_async_reset();
      test_param_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
